data_input: RTL and testbench

Processor-side input port for IN instructions, the read-direction counterpart of the processor's data output RAM. While the core executes an IN, this block stalls it, waits for the operator to press and release a debounced Enter key, then returns the switch value captured at the press, zero-extended to 32 bits. Raw board inputs are synchronized and debounced internally; the core sees only clean, clock-aligned signals.

---
 rtl/data_input.sv | 113 +++++++++++
 tb/tb_data_input.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_input.sv
// Processor-side IN port: stalls the core until a debounced Enter press/release,
// returning the switch value sampled at the press, zero-extended to 32 bits.
module data_input #(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inputRequest,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                enterKey,
  output logic [31:0]         dataIn,
  output logic                stall,
  output logic                inputReady,
  output logic                waiting
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                key_meta_q, key_meta_d;
  logic                key_sync_q, key_sync_d;
  logic [SW_WIDTH-1:0] sw_meta_q, sw_meta_d;
  logic [SW_WIDTH-1:0] sw_sync_q, sw_sync_d;
  logic                key_db_q, key_db_d;
  logic                key_db_prev_q, key_db_prev_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         data_q, data_d;

  // Synchronizers and debouncer run in every state, independent of the FSM.
  always_comb begin
    key_meta_d    = enterKey;
    key_sync_d    = key_meta_q;
    sw_meta_d     = switches;
    sw_sync_d     = sw_meta_q;
    key_db_d      = key_db_q;
    key_db_prev_d = key_db_q;
    cnt_d         = cnt_q;
    if (key_sync_q == key_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      key_db_d = key_sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A press is a debounced rising edge seen while already in WAIT_PRESS, so a
  // key held down before the request never counts.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (inputRequest) state_d = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!inputRequest) begin
          state_d = IDLE;
        end else if (key_db_q && !key_db_prev_q) begin
          data_d  = 32'(sw_sync_q);
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!key_db_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      key_meta_q    <= 1'b0;
      key_sync_q    <= 1'b0;
      sw_meta_q     <= '0;
      sw_sync_q     <= '0;
      key_db_q      <= 1'b0;
      key_db_prev_q <= 1'b0;
      cnt_q         <= '0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      key_meta_q    <= key_meta_d;
      key_sync_q    <= key_sync_d;
      sw_meta_q     <= sw_meta_d;
      sw_sync_q     <= sw_sync_d;
      key_db_q      <= key_db_d;
      key_db_prev_q <= key_db_prev_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
    end
  end

  // Stall is combinational on inputRequest so the core freezes in the request cycle.
  assign stall      = (state_q == IDLE && inputRequest) ||
                      (state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE);
  assign inputReady = (state_q == DONE);
  assign waiting    = (state_q == WAIT_PRESS);
  assign dataIn     = data_q;

endmodule

// File: tb/tb_data_input.sv
// Directed bench for data_input with a short debounce window.
module tb_data_input;

  localparam int SW_WIDTH = 16;
  localparam int DEB      = 4;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                inputRequest = 1'b0;
  logic [SW_WIDTH-1:0] switches = '0;
  logic                enterKey = 1'b0;
  logic [31:0]         dataIn;
  logic                stall, inputReady, waiting;

  int total = 0;
  int bad   = 0;
  int ready_cnt = 0;
  int base;
  logic ok;

  data_input #(.SW_WIDTH(SW_WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock(clock), .reset(reset), .inputRequest(inputRequest),
    .switches(switches), .enterKey(enterKey), .dataIn(dataIn),
    .stall(stall), .inputReady(inputReady), .waiting(waiting)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_ready(input int bound, output logic found);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (inputReady === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Every ready pulse must coincide with stall low.
  always @(negedge clock) begin
    if (inputReady === 1'b1) begin
      ready_cnt++;
      total++;
      assert (stall === 1'b0) else begin
        bad++;
        $error("FAIL ready_stall: got %b want 0", stall);
      end
    end
  end

  initial begin
    // Reset with all inputs toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      inputRequest = ~inputRequest;
      enterKey     = ~enterKey;
      switches     = 16'(i * 16'h3C3C + 16'h1111);
      tick(1);
      chk("rst_data", dataIn, 32'h0);
      chk("rst_ready", {31'b0, inputReady}, 32'h0);
    end
    inputRequest = 1'b0;
    enterKey     = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("rst_data_out", dataIn, 32'h0);
    chk("rst_waiting", {31'b0, waiting}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    tick(3);
    chk("rst_no_ready", ready_cnt, 0);

    // Basic IN
    switches = 16'hA5C3;
    base = ready_cnt;
    inputRequest = 1'b1;
    #1;
    chk("basic_stall_comb", {31'b0, stall}, 32'h1);
    tick(1);
    chk("basic_waiting", {31'b0, waiting}, 32'h1);
    enterKey = 1'b1;
    tick(10);
    chk("basic_data", dataIn, 32'h0000A5C3);
    chk("basic_wr_waiting", {31'b0, waiting}, 32'h0);
    chk("basic_wr_stall", {31'b0, stall}, 32'h1);
    enterKey = 1'b0;
    wait_ready(20, ok);
    chk("basic_ready_seen", {31'b0, ok}, 32'h1);
    inputRequest = 1'b0;
    tick(3);
    chk("basic_ready_once", ready_cnt, base + 1);
    chk("basic_data_hold", dataIn, 32'h0000A5C3);
    chk("basic_idle_stall", {31'b0, stall}, 32'h0);

    // Bounce: six toggles every 2 cycles, then hold high
    switches = 16'h0BEE;
    base = ready_cnt;
    inputRequest = 1'b1;
    tick(2);
    for (int i = 0; i < 6; i++) begin
      enterKey = ~enterKey;
      tick(2);
    end
    chk("bounce_no_capture", dataIn, 32'h0000A5C3);
    chk("bounce_waiting", {31'b0, waiting}, 32'h1);
    enterKey = 1'b1;
    tick(6);
    chk("bounce_pre_cap_wait", {31'b0, waiting}, 32'h1);
    chk("bounce_pre_cap_data", dataIn, 32'h0000A5C3);
    tick(1);
    chk("bounce_cap_wait", {31'b0, waiting}, 32'h0);
    chk("bounce_cap_data", dataIn, 32'h00000BEE);
    enterKey = 1'b0;
    wait_ready(20, ok);
    chk("bounce_ready_seen", {31'b0, ok}, 32'h1);
    inputRequest = 1'b0;
    tick(3);
    chk("bounce_ready_once", ready_cnt, base + 1);

    // Held key before request is not a press
    switches = 16'h7777;
    enterKey = 1'b1;
    tick(10);
    chk("idle_key_data", dataIn, 32'h00000BEE);
    base = ready_cnt;
    inputRequest = 1'b1;
    tick(3);
    chk("held_waiting", {31'b0, waiting}, 32'h1);
    chk("held_no_capture", dataIn, 32'h00000BEE);
    enterKey = 1'b0;
    tick(10);
    chk("held_rel_waiting", {31'b0, waiting}, 32'h1);
    chk("held_rel_data", dataIn, 32'h00000BEE);
    switches = 16'h0042;
    tick(3);
    enterKey = 1'b1;
    tick(10);
    chk("held_repress_data", dataIn, 32'h00000042);
    enterKey = 1'b0;
    wait_ready(20, ok);
    chk("held_ready_seen", {31'b0, ok}, 32'h1);
    inputRequest = 1'b0;
    tick(3);
    chk("held_ready_once", ready_cnt, base + 1);

    // Switch change after capture
    switches = 16'h1234;
    base = ready_cnt;
    inputRequest = 1'b1;
    tick(2);
    enterKey = 1'b1;
    tick(9);
    chk("post_cap_data", dataIn, 32'h00001234);
    chk("post_cap_stall", {31'b0, stall}, 32'h1);
    switches = 16'hFFFF;
    tick(5);
    chk("post_change_data", dataIn, 32'h00001234);
    enterKey = 1'b0;
    wait_ready(20, ok);
    chk("post_ready_seen", {31'b0, ok}, 32'h1);
    chk("post_ready_data", dataIn, 32'h00001234);
    inputRequest = 1'b0;
    tick(3);
    chk("post_ready_once", ready_cnt, base + 1);

    // Reset mid-read in WAIT_RELEASE
    switches = 16'h5A5A;
    inputRequest = 1'b1;
    tick(2);
    enterKey = 1'b1;
    tick(9);
    chk("mid_cap_data", dataIn, 32'h00005A5A);
    base = ready_cnt;
    reset = 1'b1;
    inputRequest = 1'b0;
    enterKey = 1'b0;
    tick(1);
    chk("mid_rst_data", dataIn, 32'h0);
    chk("mid_rst_waiting", {31'b0, waiting}, 32'h0);
    chk("mid_rst_stall", {31'b0, stall}, 32'h0);
    reset = 1'b0;
    tick(10);
    chk("mid_rst_no_ready", ready_cnt, base);

    // Full IN after the aborted one
    switches = 16'hC0DE;
    inputRequest = 1'b1;
    tick(2);
    enterKey = 1'b1;
    tick(10);
    chk("after_rst_data", dataIn, 32'h0000C0DE);
    enterKey = 1'b0;
    wait_ready(20, ok);
    chk("after_rst_ready_seen", {31'b0, ok}, 32'h1);
    inputRequest = 1'b0;
    tick(3);
    chk("after_rst_ready_once", ready_cnt, base + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
